// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares a 4:1 one-bit mux among four requesters.
// A tenure is capped at MAX_BURST cycles only while someone else is waiting.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] a,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [3:0] owner_oh;
  logic [3:0] others;
  logic       at_limit;
  logic       tenure_end;
  logic [3:0] search_mask;
  logic [1:0] search_start;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       found;

  // Current owner status and end-of-tenure condition
  always_comb begin
    owner_oh   = 4'b0001 << sel;
    others     = req & ~owner_oh;
    at_limit   = (cnt == CNT_MAX);
    tenure_end = !req[sel] || (at_limit && (|others));
  end

  // Rotating winner search: from ptr when idle, from owner+1 over the others at hand-over
  always_comb begin
    search_start = ptr;
    search_mask  = req;
    if (state == GRANT) begin
      search_start = sel + 2'd1;
      search_mask  = others;
    end
    found  = 1'b0;
    winner = search_start;
    cand   = 2'd0;
    // Scan farthest-first so the closest requester to the start position wins
    for (int i = 3; i >= 0; i--) begin
      cand = search_start + 2'(i);
      if (search_mask[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Arbitration FSM with registered grant/sel/busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      busy  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            grant <= 4'b0001 << winner;
            sel   <= winner;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            ptr <= sel + 2'd1;
            cnt <= '0;
            if (found) begin
              grant <= 4'b0001 << winner;
              sel   <= winner;
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
              busy  <= 1'b0;
            end
          end else if (!at_limit) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shared mux output, forced low when nobody holds the grant
  assign y = busy & a[sel];

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin arbiter and sequencer that shares the 4:1 one-bit multiplexer datapath among four requesters.
- Each requester raises a request line. The block grants one requester at a time and drives the mux select from the registered grant.
- It bounds each tenure to MAX_BURST cycles so no requester starves the others.
- It sits between requester logic and the shared mux output `y`.

## Interface
- MAX_BURST, 4, maximum consecutive grant cycles per tenure while other requests wait (legal range 1..16)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- req  input  4  request lines, bit k = requester k
- a  input  4  mux data, bit k = data bit of requester k
- grant  output  4  one-hot registered grant; 4'b0000 when idle
- sel  output  2  registered select, equals index of granted requester; holds last value when idle
- busy  output  1  registered, high when any grant is active
- y  output  1  a[sel] when busy, else 0 (combinational from registered sel/busy)

## Operation
- States: IDLE, GRANT. Internal state: `ptr[1:0]` (next priority position), `cnt` (burst counter, width to hold MAX_BURST-1).
- Winner search: scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first one with req high wins.
- IDLE:
  - If req != 0, go to GRANT: grant <= onehot(winner), sel <= winner, busy <= 1, cnt <= 0.
  - Otherwise stay in IDLE with grant = 0 and busy = 0.
- GRANT, with current owner s = sel. The tenure ends when:
  - req[s] == 0, or
  - cnt == MAX_BURST-1 and another req bit (not s) is high.
- GRANT, tenure continues: grant and sel hold. cnt increments, saturating at MAX_BURST-1.
- GRANT, at tenure end, ptr <= s+1, then:
  - If another request is pending, re-arbitrate in the same edge with search start s+1. The new winner is granted with no idle gap and cnt <= 0.
  - Otherwise go to IDLE with grant <= 0 and busy <= 0.
- Work-conserving: if s is the sole requester at cnt == MAX_BURST-1, the tenure continues with no forced release.
- Owner s re-requesting after its own release:
  - It is eligible again only after the others in rotation.
  - If it is the only requester, it wins; this is a new tenure with cnt = 0.
- A req withdrawn before it is granted is simply not seen; no pending state is stored.
- grant is always one-hot or zero. sel always equals the index of the set grant bit while busy.
- y is the shared mux output: a[sel] gated by busy.

## Timing
- Reset (rst_n low at a rising edge): grant = 4'b0000, sel = 2'b00, busy = 0, y = 0, ptr = 0, cnt = 0, state IDLE. All requests are ignored in that cycle.
- Reset asserted mid-tenure drops grant on the same edge. The first arbitration after reset starts search at requester 0.
- Grant latency: req sampled high at edge N (state IDLE) gives grant at edge N, visible during cycle N→N+1.
- Release latency: req[s] sampled low at edge N gives grant[s] low from edge N. The next grant, if any, appears at the same edge.
- Maximum tenure under contention is exactly MAX_BURST cycles with grant high.
- Worst-case wait for a continuously requesting requester: 3·MAX_BURST cycles plus 1.
- y follows a combinationally within the cycle. The select path changes only at clock edges.

## Test plan
- Reset and idle:
  - Stimulus: rst_n=0 for 2 cycles with req=4'b1111, then rst_n=1 and req=0.
  - Required: grant=0, sel=0, busy=0 and y=0 throughout.
- Single request:
  - Stimulus: req=4'b0100 held for 6 cycles, a=4'b0100, then req drops.
  - Required: grant=4'b0100 and sel=2 one edge after req, y=1 while granted.
  - Required: grant is not cut at MAX_BURST; grant=0 the edge after req drops.
- Round-robin with MAX_BURST=4:
  - Stimulus: req=4'b1111 held from reset.
  - Required: grants 0001,0010,0100,1000,0001, each held exactly 4 cycles with no idle gap.
- Early release and skip:
  - Stimulus: req=4'b1010; requester 1 drops req after 2 cycles of grant.
  - Required: grant moves 0010→1000 on that edge. Requester 1 then re-requests with req=4'b1010.
  - Required: grant returns to 0010 only after requester 3's tenure ends.
- Data path sweep:
  - Stimulus: for each granted requester k, sweep a over 0..15.
  - Required: y == a[k] every cycle.
  - Required: with all req=0, y=0 for all values of a.
- Reset mid-tenure:
  - Stimulus: req=4'b0011 with grant=0010 active; pull rst_n low for 1 cycle.
  - Required: grant=0 at that edge, then grant=0001 the edge after rst_n returns high (ptr reset to 0).
